// File: rtl/mors_to_num.sv
// Serial Morse receiver: measures mark/space runs on a one-unit-per-clock line
// and turns each five-element digit character into a digit strobe or an error strobe.
module mors_to_num #(
  parameter int DASH_LEN = 3,
  parameter int GAP_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mors,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       sym_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_e;

  localparam logic [2:0] DASH_CNT = 3'(DASH_LEN);
  localparam logic [2:0] GAP_CNT  = 3'(GAP_LEN);

  state_e     state_q, state_d;
  logic [4:0] shreg_q, shreg_d;
  logic [2:0] elem_cnt_q, elem_cnt_d;
  logic [2:0] mark_cnt_q, mark_cnt_d;
  logic [2:0] space_cnt_q, space_cnt_d;
  logic       bad_q, bad_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       sym_err_q, sym_err_d;

  logic [3:0] dec_digit;
  logic       dec_ok;

  // Element pattern, first arrival in bit 4, mapped to the digit it encodes.
  always_comb begin
    dec_digit = 4'd0;
    dec_ok    = 1'b1;
    case (shreg_q)
      5'b01111: dec_digit = 4'd1;
      5'b00111: dec_digit = 4'd2;
      5'b00011: dec_digit = 4'd3;
      5'b00001: dec_digit = 4'd4;
      5'b00000: dec_digit = 4'd5;
      5'b10000: dec_digit = 4'd6;
      5'b11000: dec_digit = 4'd7;
      5'b11100: dec_digit = 4'd8;
      5'b11110: dec_digit = 4'd9;
      5'b11111: dec_digit = 4'd0;
      default:  dec_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    elem_cnt_d    = elem_cnt_q;
    mark_cnt_d    = mark_cnt_q;
    space_cnt_d   = space_cnt_q;
    bad_d         = bad_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    sym_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mors) begin
          state_d    = MARK;
          mark_cnt_d = 3'd1;
        end
      end

      MARK: begin
        if (mors) begin
          if (mark_cnt_q != 3'd7) mark_cnt_d = mark_cnt_q + 3'd1;
        end else begin
          if (mark_cnt_q == 3'd1) begin
            shreg_d = {shreg_q[3:0], 1'b0};
          end else if (mark_cnt_q == DASH_CNT) begin
            shreg_d = {shreg_q[3:0], 1'b1};
          end else begin
            bad_d = 1'b1;
          end
          if (elem_cnt_q != 3'd6) elem_cnt_d = elem_cnt_q + 3'd1;
          // A sixth element can never form a legal digit.
          if (elem_cnt_q >= 3'd5) bad_d = 1'b1;
          mark_cnt_d  = 3'd0;
          space_cnt_d = 3'd1;
          state_d     = SPACE;
        end
      end

      SPACE: begin
        if (mors) begin
          state_d     = MARK;
          mark_cnt_d  = 3'd1;
          space_cnt_d = 3'd0;
        end else if (space_cnt_q == GAP_CNT - 3'd1) begin
          // This zero completes the character gap: decide and start over.
          if ((elem_cnt_q == 3'd5) && !bad_q && dec_ok) begin
            digit_valid_d = 1'b1;
            digit_d       = dec_digit;
          end else begin
            sym_err_d = 1'b1;
          end
          shreg_d     = 5'd0;
          elem_cnt_d  = 3'd0;
          bad_d       = 1'b0;
          space_cnt_d = 3'd0;
          state_d     = IDLE;
        end else begin
          space_cnt_d = space_cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= 5'd0;
      elem_cnt_q    <= 3'd0;
      mark_cnt_q    <= 3'd0;
      space_cnt_q   <= 3'd0;
      bad_q         <= 1'b0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      sym_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      elem_cnt_q    <= elem_cnt_d;
      mark_cnt_q    <= mark_cnt_d;
      space_cnt_q   <= space_cnt_d;
      bad_q         <= bad_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      sym_err_q     <= sym_err_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign sym_err     = sym_err_q;

endmodule

// File: tb/tb_mors_to_num.sv
// Bench for mors_to_num: per-cycle reference model on every driven sample, a
// table of single characters, hand-written multi-cycle sequences and random traffic.
module tb_mors_to_num;

  localparam int DASH_LEN = 3;
  localparam int GAP_LEN  = 3;

  logic       clk;
  logic       rst;
  logic       mors;
  logic [3:0] digit;
  logic       digit_valid;
  logic       sym_err;

  mors_to_num #(.DASH_LEN(DASH_LEN), .GAP_LEN(GAP_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .mors        (mors),
    .digit       (digit),
    .digit_valid (digit_valid),
    .sym_err     (sym_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [5:0] exp_q[$];

  int n_valid_seen = 0;
  int n_err_seen   = 0;
  int got_q[$];

  // ---------------- reference model ----------------
  int   m_cur_mark;
  int   m_marks[$];
  int   m_zero_run;
  logic [3:0] m_digit;

  // Digit d sends dots first then dashes for 1..5, dashes first then dots for 6..9, all dashes for 0.
  function automatic bit is_dot(int d, int i);
    if (d >= 1 && d <= 5) return (i < d);
    if (d >= 6)           return (i >= d - 5);
    return 1'b0;
  endfunction

  function automatic int model_decode();
    bit ok;
    if (m_marks.size() != 5) return -1;
    for (int i = 0; i < 5; i++)
      if (m_marks[i] != 1 && m_marks[i] != DASH_LEN) return -1;
    for (int d = 0; d < 10; d++) begin
      ok = 1'b1;
      for (int i = 0; i < 5; i++)
        if ((m_marks[i] == 1) != is_dot(d, i)) ok = 1'b0;
      if (ok) return d;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cur_mark = 0;
    m_marks.delete();
    m_zero_run = 0;
    m_digit    = 4'd0;
  endtask

  // Returns {valid, err, digit} expected after the edge that samples m.
  function automatic logic [5:0] model_step(bit m);
    int   d;
    logic v, e;
    v = 1'b0;
    e = 1'b0;
    if (m) begin
      m_cur_mark++;
      m_zero_run = 0;
    end else begin
      if (m_cur_mark > 0) begin
        m_marks.push_back(m_cur_mark);
        m_cur_mark = 0;
        m_zero_run = 1;
      end else if (m_marks.size() > 0) begin
        m_zero_run++;
      end
      if (m_marks.size() > 0 && m_zero_run == GAP_LEN) begin
        d = model_decode();
        if (d >= 0) begin
          v = 1'b1;
          m_digit = 4'(d);
        end else begin
          e = 1'b1;
        end
        m_marks.delete();
        m_zero_run = 0;
      end
    end
    return {v, e, m_digit};
  endfunction

  // ---------------- check / driver tasks ----------------
  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic step(bit m, bit r);
    logic [5:0] exp;
    @(negedge clk);
    mors = m;
    rst  = r;
    if (r) begin
      model_reset();
      exp_q.push_back(6'd0);
    end else begin
      exp_q.push_back(model_step(m));
    end
    @(posedge clk);
    #1;
    cyc++;
    exp = exp_q.pop_front();
    check("outputs {valid,err,digit}", int'({digit_valid, sym_err, digit}), int'(exp));
    if (digit_valid) begin
      n_valid_seen++;
      got_q.push_back(int'(digit));
    end
    if (sym_err) n_err_seen++;
  endtask

  task automatic send_line(string line);
    for (int i = 0; i < line.len(); i++) step(line[i] == "1", 1'b0);
  endtask

  task automatic clear_seen();
    n_valid_seen = 0;
    n_err_seen   = 0;
    got_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      line;
    bit         exp_err;
    logic [3:0] exp_digit;
  } vec_t;

  vec_t vecs[9];
  logic [3:0] last_good;

  initial begin
    vecs[0] = '{"111011101010100000",     1'b0, 4'd7};
    vecs[1] = '{"110111011101110111000",  1'b1, 4'd0};
    vecs[2] = '{"1010101000",             1'b1, 4'd0};
    vecs[3] = '{"10101010101000",         1'b1, 4'd0};
    vecs[4] = '{"10101010100000",         1'b0, 4'd5};
    vecs[5] = '{"101011101110111000",     1'b0, 4'd2};
    vecs[6] = '{"1011101011101000",       1'b1, 4'd0};
    vecs[7] = '{"11101110111011101000",   1'b0, 4'd9};
    vecs[8] = '{"1110111011101110111000", 1'b0, 4'd0};

    mors = 1'b0;
    rst  = 1'b1;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("reset digit", int'(digit), 0);
    check("reset strobes", int'({digit_valid, sym_err}), 0);

    // Single characters from the table
    last_good = 4'd0;
    for (int v = 0; v < 9; v++) begin
      clear_seen();
      send_line(vecs[v].line);
      step(1'b0, 1'b0);
      if (!vecs[v].exp_err) last_good = vecs[v].exp_digit;
      check($sformatf("vec%0d valid count", v), n_valid_seen, vecs[v].exp_err ? 0 : 1);
      check($sformatf("vec%0d err count", v), n_err_seen, vecs[v].exp_err ? 1 : 0);
      check($sformatf("vec%0d digit", v), int'(digit), int'(last_good));
    end

    // Digit 0 then digit 1 with exactly GAP_LEN zeros between, no idle
    clear_seen();
    send_line("1110111011101110111000");
    send_line("10111011101110111000");
    check("b2b strobe count", n_valid_seen, 2);
    check("b2b err count", n_err_seen, 0);
    check("b2b first digit", (got_q.size() > 0) ? got_q[0] : -1, 0);
    check("b2b second digit", (got_q.size() > 1) ? got_q[1] : -1, 1);

    // Reset in the middle of digit 9, then a full digit 4
    clear_seen();
    send_line("11101110");
    step(1'b1, 1'b1);
    check("mid reset outputs", int'({digit_valid, sym_err, digit}), 0);
    send_line("10101010111000");
    step(1'b0, 1'b0);
    check("post reset valid count", n_valid_seen, 1);
    check("post reset err count", n_err_seen, 0);
    check("post reset digit", int'(digit), 4);

    // Long idle then a stuck mark
    clear_seen();
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    check("idle strobes", n_valid_seen + n_err_seen, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("stuck mark no strobe yet", n_valid_seen + n_err_seen, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("stuck mark err count", n_err_seen, 1);
    check("stuck mark valid count", n_valid_seen, 0);

    // Random traffic against the model
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        int d;
        d = $urandom_range(0, 9);
        for (int i = 0; i < 5; i++) begin
          for (int k = 0; k < (is_dot(d, i) ? 1 : DASH_LEN); k++) step(1'b1, 1'b0);
          if (i < 4)
            for (int k = 0; k < $urandom_range(1, GAP_LEN - 1); k++) step(1'b0, 1'b0);
        end
      end else begin
        int n;
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) begin
          for (int k = 0; k < $urandom_range(1, 9); k++) step(1'b1, 1'b0);
          if (i < n - 1)
            for (int k = 0; k < $urandom_range(1, GAP_LEN - 1); k++) step(1'b0, 1'b0);
        end
      end
      for (int k = 0; k < GAP_LEN + $urandom_range(0, 3); k++) step(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mors_to_num.md
Name: mors_to_num

Overview:
- Downstream consumer of the digit-to-Morse serializer.
- Samples the serial Morse line once per clock, with one clock equal to one Morse unit.
- Classifies mark runs as dot or dash and groups elements into characters using space runs.
- Emits the decoded decimal digit with a one-cycle valid strobe, or an error strobe for malformed characters. Used for loopback checking of the serializer and as the receive side of the link.

Parameters:
- DASH_LEN, 3, mark length in clocks classified as dash. A mark of exactly 1 is a dot. Legal range 2..6.
- GAP_LEN, 3, consecutive space clocks that terminate a character. Legal range 2..7.

Ports:
- clk  input  1  system clock, one Morse unit per cycle
- rst  input  1  synchronous active-high reset
- mors  input  1  serial Morse line; 1 = key down (mark), 0 = key up (space)
- digit  output  4  decoded digit 0..9; valid only while digit_valid=1
- digit_valid  output  1  one-cycle strobe, digit holds a new decoded value
- sym_err  output  1  one-cycle strobe, malformed character discarded

Behaviour:
- Reset: sync on rst=1. Outputs: digit=0, digit_valid=0, sym_err=0. Internal state: IDLE, element shift register=0, element count=0, mark and space counters=0, bad flag=0. Reset mid-character discards the partial character with no strobe.
- Counters:
  - Mark counter is 3 bits and saturates at 7.
  - Space counter is 3 bits and saturates at GAP_LEN.
  - Element count is 3 bits and saturates at 6. Any value above 5 sets bad.
- Element encoding: dot=0, dash=1, shifted in LSB-first-arrival. After 5 elements the first element is bit 4.
- FSM states:
  - IDLE:
    - mors=0: stay; no strobes however long the line idles.
    - mors=1: go to MARK; mark counter=1.
  - MARK:
    - mors=1: increment mark counter.
    - mors=0: close the mark. Count 1 shifts in a dot; count==DASH_LEN shifts in a dash; any other length sets bad and shifts nothing. Increment element count. Go to SPACE with space counter=1.
  - SPACE:
    - mors=1 with space counter<GAP_LEN: intra-character gap. Go to MARK, mark counter=1.
    - mors=0: increment space counter. When it reaches GAP_LEN, evaluate the character and go to IDLE.
    - Edge case: if GAP_LEN==1 were allowed, evaluation would occur on entry; this is disallowed by the legal range.
- Evaluation is legal only when element count==5 and bad==0. Pattern maps to digit:
  - 01111 -> 1
  - 00111 -> 2
  - 00011 -> 3
  - 00001 -> 4
  - 00000 -> 5
  - 10000 -> 6
  - 11000 -> 7
  - 11100 -> 8
  - 11110 -> 9
  - 11111 -> 0
- Evaluation result:
  - Legal: digit_valid=1 for exactly one cycle, digit loaded.
  - Otherwise: sym_err=1 for one cycle, digit unchanged.
  - Shift register, element count and bad are cleared in both cases.
- Latency: strobe is asserted in the cycle after the clock edge that samples the GAP_LEN-th consecutive 0.
- Ordering and line conditions:
  - digit_valid and sym_err are never high together.
  - At most one strobe per character.
  - Back-to-back characters separated by exactly GAP_LEN zeros decode without loss; the upstream reload cycle holds the line at 0 and counts as a space.
  - A mark held indefinitely saturates the mark counter and is flagged bad on release.
  - A line stuck at 1 produces no strobe until release plus GAP_LEN zeros.

Test Plan:
- Digit 7: drive 111011101010100 then 000 -> digit_valid one cycle 3 clocks after last 1 falls, digit=7, sym_err=0.
- Digit 0 then digit 1, back-to-back, exactly 3 zeros between, no idle -> two strobes, digit=0 then digit=1, no sym_err.
- Bad mark: 11 (length 2) followed by four dashes and gap -> sym_err one cycle, digit_valid=0, digit retains prior value.
- Wrong element count: 4 dots plus gap -> sym_err; then 6 dots plus gap -> sym_err; then valid digit 5 (10101010100 plus 000) -> digit=5, proving state clears.
- Reset mid-character: assert rst for 1 cycle after 2 dashes of digit 9, then send full digit 4 -> no strobe for the partial character, single digit_valid with digit=4. All outputs 0 during reset.
- Long idle and stuck mark: 50 zeros -> no strobes. Then 20 ones plus 3 zeros -> sym_err exactly once.
